// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential shift-and-add multiplier with a valid/acknowledge handshake.
// Operands are captured in IDLE, multiplied one multiplier bit per clock in
// CALC, and the product is held in DONE until the consumer acknowledges it.
// Signed operands are handled by multiplying magnitudes and negating the
// result when the operand signs differ.
//
// Parameters:
//   WIDTH       operand width; the product is 2*WIDTH bits (WIDTH >= 2)
//   EARLY_TERM  1 = stop as soon as the remaining multiplier bits are zero
//
// Ports:
//   Clock        rising-edge clock
//   Reset        asynchronous active-low reset
//   iValid_Data  operands valid, accepted only while oReady is high
//   iSigned      1 = two's-complement operands, sampled with the operands
//   iData_A      multiplicand
//   iData_B      multiplier
//   iAck         consumer acknowledge, honoured only while oDone is high
//   oReady       idle and able to accept operands
//   oDone        oProduct valid, held until acknowledged
//   oProduct     registered product
//   oCycles      number of CALC iterations used for the last result
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       iValid_Data,
  input  logic                       iSigned,
  input  logic [WIDTH-1:0]           iData_A,
  input  logic [WIDTH-1:0]           iData_B,
  input  logic                       iAck,
  output logic                       oReady,
  output logic                       oDone,
  output logic [2*WIDTH-1:0]         oProduct,
  output logic [$clog2(WIDTH+1)-1:0] oCycles
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic               sign_q,    sign_d;
  logic [2*WIDTH-1:0] aReg_q,    aReg_d;
  logic [WIDTH-1:0]   bReg_q,    bReg_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CW-1:0]      count_q,   count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      cycles_q,  cycles_d;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] nextAcc;
  logic [CW-1:0]      countInc;
  logic               lastIter;

  // Operand magnitudes. The most negative value negates to itself, which
  // read as unsigned is exactly its magnitude, so no extra bit is needed.
  always_comb begin
    magA = (iSigned && iData_A[WIDTH-1]) ? -iData_A : iData_A;
    magB = (iSigned && iData_B[WIDTH-1]) ? -iData_B : iData_B;
  end

  // One add-and-shift step plus the termination test for the current edge.
  always_comb begin
    nextAcc  = acc_q + (bReg_q[0] ? aReg_q : '0);
    countInc = count_q + 1'b1;
    lastIter = (countInc == CW'(WIDTH)) ||
               (EARLY_TERM && ((bReg_q >> 1) == '0));
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      aReg_q    <= '0;
      bReg_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      aReg_q    <= aReg_d;
      bReg_q    <= bReg_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
      cycles_q  <= cycles_d;
    end
  end

  // Next-state and datapath update. Product and cycle count are only
  // written on the final CALC edge so they persist through DONE and IDLE.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    aReg_d    = aReg_q;
    bReg_d    = bReg_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    cycles_d  = cycles_q;
    case (state_q)
      IDLE: begin
        if (iValid_Data) begin
          sign_d  = iSigned & (iData_A[WIDTH-1] ^ iData_B[WIDTH-1]);
          aReg_d  = {{WIDTH{1'b0}}, magA};
          bReg_d  = magB;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = nextAcc;
        aReg_d  = aReg_q << 1;
        bReg_d  = bReg_q >> 1;
        count_d = countInc;
        if (lastIter) begin
          product_d = sign_q ? -nextAcc : nextAcc;
          cycles_d  = countInc;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (iAck) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oReady   = (state_q == IDLE);
  assign oDone    = (state_q == DONE);
  assign oProduct = product_q;
  assign oCycles  = cycles_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Drives three multiplier instances in lockstep from shared inputs:
//   dut0  WIDTH=32, EARLY_TERM=1
//   dut1  WIDTH=32, EARLY_TERM=0
//   dut2  WIDTH=8,  EARLY_TERM=1 (low byte of the operands)
// Expected products and iteration counts come from plain arithmetic on the
// operand values, independent of the datapath structure.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic        clock;
  logic        resetN;
  logic        valid;
  logic        sgn;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        ack;

  logic [2:0]  rdy;
  logic [2:0]  dn;
  logic [63:0] prod0;
  logic [63:0] prod1;
  logic [15:0] prod2;
  logic [5:0]  cyc0;
  logic [5:0]  cyc1;
  logic [3:0]  cyc2;

  int checks = 0;
  int errors = 0;

  logic [63:0] expP [3];
  logic [63:0] expC [3];

  shift_add_multiplier #(.WIDTH(32), .EARLY_TERM(1'b1)) dut0 (
    .Clock(clock), .Reset(resetN), .iValid_Data(valid), .iSigned(sgn),
    .iData_A(dataA), .iData_B(dataB), .iAck(ack),
    .oReady(rdy[0]), .oDone(dn[0]), .oProduct(prod0), .oCycles(cyc0)
  );

  shift_add_multiplier #(.WIDTH(32), .EARLY_TERM(1'b0)) dut1 (
    .Clock(clock), .Reset(resetN), .iValid_Data(valid), .iSigned(sgn),
    .iData_A(dataA), .iData_B(dataB), .iAck(ack),
    .oReady(rdy[1]), .oDone(dn[1]), .oProduct(prod1), .oCycles(cyc1)
  );

  shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(1'b1)) dut2 (
    .Clock(clock), .Reset(resetN), .iValid_Data(valid), .iSigned(sgn),
    .iData_A(dataA[7:0]), .iData_B(dataB[7:0]), .iAck(ack),
    .oReady(rdy[2]), .oDone(dn[2]), .oProduct(prod2), .oCycles(cyc2)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference product: interpret the low w bits of each operand as signed
  // or unsigned integers, multiply, and keep the low 2*w bits.
  function automatic logic [63:0] refProduct(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input bit s, input int w);
    longint m;
    longint pa;
    longint pb;
    longint p;
    m  = (64'sd1 <<< w) - 1;
    pa = longint'({32'b0, a}) & m;
    pb = longint'({32'b0, b}) & m;
    if (s && a[w-1]) pa = pa - (64'sd1 <<< w);
    if (s && b[w-1]) pb = pb - (64'sd1 <<< w);
    p = pa * pb;
    if (w < 32) p = p & ((64'sd1 <<< (2*w)) - 1);
    return 64'(p);
  endfunction

  // Reference iteration count: w without early termination, otherwise one
  // more than the index of the highest set bit of |B| (at least 1).
  function automatic logic [63:0] refCycles(input logic [31:0] b,
                                            input bit s, input int w,
                                            input bit et);
    longint mag;
    int n;
    if (!et) return 64'(w);
    mag = longint'({32'b0, b}) & ((64'sd1 <<< w) - 1);
    if (s && b[w-1]) mag = (64'sd1 <<< w) - mag;
    n = 1;
    for (int i = 0; i < w; i++)
      if (mag[i]) n = i + 1;
    return 64'(n);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for all instances to be idle, then present operands for
  // exactly one capture edge. Inputs are scrambled afterwards.
  task automatic startOp(input logic [31:0] a, input logic [31:0] b,
                         input bit s);
    int t;
    t = 0;
    while (rdy !== 3'b111 && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    checkOutput("ready_before_op", 64'(rdy), 64'h7);
    expP[0] = refProduct(a, b, s, 32);
    expP[1] = expP[0];
    expP[2] = refProduct(a, b, s, 8);
    expC[0] = refCycles(b, s, 32, 1'b1);
    expC[1] = refCycles(b, s, 32, 1'b0);
    expC[2] = refCycles(b, s, 8, 1'b1);
    @(negedge clock);
    dataA = a;
    dataB = b;
    sgn   = s;
    valid = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
    sgn   = 1'($urandom);
  endtask

  // Full transaction: capture, measure latency of each instance, check
  // results, optionally hold without ack, optionally pulse valid in CALC.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input bit s, input int hold,
                               input bit pulseValid);
    int doneAt [3];
    bit overlap;
    doneAt  = '{0, 0, 0};
    overlap = 1'b0;
    startOp(a, b, s);
    for (int c = 1; c <= 40 && dn !== 3'b111; c++) begin
      if (pulseValid && c == 2) valid = 1'b1;
      @(posedge clock); #1;
      valid = 1'b0;
      for (int k = 0; k < 3; k++)
        if (dn[k] === 1'b1 && doneAt[k] == 0) doneAt[k] = c;
      if ((rdy & dn) !== 3'b000) overlap = 1'b1;
    end
    checkOutput("latency0", 64'(doneAt[0]), expC[0]);
    checkOutput("latency1", 64'(doneAt[1]), expC[1]);
    checkOutput("latency2", 64'(doneAt[2]), expC[2]);
    checkOutput("product0", prod0, expP[0]);
    checkOutput("product1", prod1, expP[1]);
    checkOutput("product2", 64'(prod2), expP[2]);
    checkOutput("cycles0", 64'(cyc0), expC[0]);
    checkOutput("cycles1", 64'(cyc1), expC[1]);
    checkOutput("cycles2", 64'(cyc2), expC[2]);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clock); #1;
        if ((rdy & dn) !== 3'b000) overlap = 1'b1;
      end
      checkOutput("hold_done", 64'(dn), 64'h7);
      checkOutput("hold_ready", 64'(rdy), 64'h0);
      checkOutput("hold_product0", prod0, expP[0]);
      checkOutput("hold_product2", 64'(prod2), expP[2]);
    end
    @(negedge clock);
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
    checkOutput("after_ack_ready", 64'(rdy), 64'h7);
    checkOutput("after_ack_done", 64'(dn), 64'h0);
    checkOutput("ready_done_overlap", 64'(overlap), 64'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;

    resetN = 1'b0;
    valid  = 1'b0;
    sgn    = 1'b0;
    dataA  = '0;
    dataB  = '0;
    ack    = 1'b0;

    #2;
    checkOutput("reset_ready", 64'(rdy), 64'h7);
    checkOutput("reset_done", 64'(dn), 64'h0);
    checkOutput("reset_product0", prod0, 64'h0);
    checkOutput("reset_cycles0", 64'(cyc0), 64'h0);
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;

    $display("[TB] directed unsigned cases");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    applyStimulus(32'h00000000, 32'hFFFFFFFF, 1'b0, 0, 1'b0);
    applyStimulus(32'd10000,    32'd4500,     1'b0, 0, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b0, 0, 1'b0);
    applyStimulus(32'h000000FF, 32'h000000FF, 1'b0, 0, 1'b0);

    $display("[TB] directed signed cases");
    applyStimulus(-32'sd3,      32'd7,        1'b1, 0, 1'b0);
    applyStimulus(32'h80000000, 32'h80000000, 1'b1, 0, 1'b0);
    applyStimulus(32'd5,        32'hFFFFFFFF, 1'b1, 0, 1'b0);
    applyStimulus(32'h000000FF, 32'h000000FF, 1'b1, 0, 1'b0);
    applyStimulus(32'h00000080, 32'h00000080, 1'b1, 0, 1'b0);

    $display("[TB] handshake cases");
    @(negedge clock);
    ack = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    ack = 1'b0;
    checkOutput("idle_ack_ready", 64'(rdy), 64'h7);
    checkOutput("idle_ack_done", 64'(dn), 64'h0);
    applyStimulus(32'h12345678, 32'h0000F00D, 1'b0, 20, 1'b0);
    applyStimulus(32'hDEADBEEF, 32'h7654321F, 1'b1, 0, 1'b1);

    $display("[TB] randomized cases");
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) rb = -rb;
      rs = 1'($urandom);
      applyStimulus(ra, rb, rs, 0, 1'b0);
    end

    $display("[TB] reset during CALC");
    applyStimulus(32'h0000ABCD, 32'h00001234, 1'b0, 0, 1'b0);
    startOp(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("midcalc_reset_ready", 64'(rdy), 64'h7);
    checkOutput("midcalc_reset_done", 64'(dn), 64'h0);
    checkOutput("midcalc_reset_product0", prod0, 64'h0);
    checkOutput("midcalc_reset_product2", 64'(prod2), 64'h0);
    checkOutput("midcalc_reset_cycles1", 64'(cyc1), 64'h0);
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus(32'd10000, 32'd4500, 1'b0, 0, 1'b0);
    applyStimulus(-32'sd3, 32'd7, 1'b1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
